// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling, valid/ready holding register,
// framing-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  clks_per_bit,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  clr_err,
    output logic                  busy
);

    localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_BIT = IDX_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [CNT_WIDTH-1:0]  r_n;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [IDX_WIDTH-1:0]  r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_byte_done;
    logic                  r_frame_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    logic [CNT_WIDTH-1:0]  w_half_m1;
    logic [CNT_WIDTH-1:0]  w_full_m1;
    logic                  w_half_hit;
    logic                  w_full_hit;
    logic                  w_cnt_clr;
    logic                  w_cnt_run;
    logic                  w_latch_n;
    logic                  w_bit_clr;
    logic                  w_shift_en;
    logic                  w_stop_good;
    logic                  w_stop_bad;
    logic                  w_load;

    assign w_half_m1  = (r_n >> 1) - CNT_WIDTH'(1);
    assign w_full_m1  = r_n - CNT_WIDTH'(1);
    assign w_half_hit = (r_cnt == w_half_m1);
    assign w_full_hit = (r_cnt == w_full_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_run   = 1'b0;
        w_latch_n   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_next    = S_START;
                    w_latch_n = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            S_START: begin
                w_cnt_run = 1'b1;
                if (w_half_hit) begin
                    w_cnt_clr = 1'b1;
                    w_bit_clr = 1'b1;
                    // A start bit that is high again at mid-bit was only a glitch
                    w_next    = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                w_cnt_run = 1'b1;
                if (w_full_hit) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_cnt_run = 1'b1;
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_stop_good = 1'b1;
                        w_next      = S_IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_next     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Counter rests at zero outside START/DATA/STOP so it never exceeds n_reg-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n       <= '0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_latch_n) begin
                r_n <= clks_per_bit;
            end
            if (w_cnt_clr || !w_cnt_run) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            if (w_bit_clr) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + IDX_WIDTH'(1);
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
            end
        end
    end

    assign w_load = r_byte_done && (!r_valid || ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_byte_done <= w_stop_good;
            r_frame_err <= w_stop_bad;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (r_byte_done && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
